csr_uart_master: RTL and testbench
==================================

// Module: csr_uart_master
// PURPOSE
//  UART-driven initiator for the CSR i/o bus: parses host command frames from the rx UART byte
//  stream, issues single 16-bit i/o writes/reads to the CSR address space, returns ack/read data
//  via the tx UART. Debug/bring-up path; shares the bus with the J1 core via external req/gnt mux.
// PARAMETERS
//  TIMEOUT_CYCLES  1_000_000  max clk cycles between frame bytes before frame abort
//  CMD_WR          8'h57      'W' opcode: write frame
//  CMD_RD          8'h52      'R' opcode: read frame
//  RSP_ACK         8'h4B      'K' reply after a completed write
//  RSP_ERR         8'h3F      '?' reply to an unknown opcode
// PORTS
//  clk          in   1   system clock
//  rst          in   1   reset, asynchronous, active-high
//  rx_valid     in   1   rx UART holds an unread byte
//  rx_data      in   8   rx byte, valid combinationally while rx_valid
//  rx_rd        out  1   one-cycle pop of rx byte (byte sampled in same cycle)
//  tx_ready     in   1   tx UART can accept a byte
//  tx_wr        out  1   one-cycle push of tx_wdata
//  tx_wdata     out  8   tx byte
//  bus_req      out  1   request CSR bus ownership
//  bus_gnt      in   1   ownership granted; stays high while bus_req high
//  m_addr       out  16  i/o address
//  m_wdata      out  16  i/o write data
//  m_io_wr      out  1   i/o write strobe, one cycle
//  m_io_rd      out  1   i/o read strobe, one cycle
//  m_io_din     in   16  read data, combinational, valid in m_io_rd cycle
//  busy         out  1   high in every state except IDLE
//  err_timeout  out  1   one-cycle pulse on inter-byte timeout abort
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, timeout counter 0, address/data/readback regs 0.
//  - Frames (bytes MSB first): W AH AL DH DL -> write, reply K. R AH AL -> read, reply RH RL.
//  - FSM: IDLE -> OP -> ADDR_H -> ADDR_L -> [DATA_H -> DATA_L (W only)] -> REQ -> ACCESS -> RSP_0
//    -> [RSP_1 (R only)] -> IDLE. Unknown opcode in OP: -> RSP_0 sending RSP_ERR -> IDLE.
//  - IDLE->OP when rx_valid; byte consumption: rx_rd=1 exactly one cycle per byte, only when
//    rx_valid=1 in a receive state (OP..DATA_L); never two pops in consecutive cycles.
//  - REQ: bus_req=1; advance to ACCESS the cycle bus_gnt seen high. ACCESS: bus_req=1 and exactly
//    one m_io_wr or m_io_rd cycle; m_addr/m_wdata stable from REQ through ACCESS; m_io_din latched
//    into readback reg at end of ACCESS. bus_req drops the cycle after ACCESS. Strobes only ever
//    asserted with bus_gnt=1; m_addr/m_wdata hold last values otherwise.
//  - Latency: last frame byte pop -> strobe = 2 cycles when gnt already high.
//  - RSP states: tx_wr=1 one cycle when tx_ready=1, else wait (no timeout while waiting for tx).
//    After a tx_wr, next tx_wr no earlier than 2 cycles later (UART ready deasserts with 1-cycle lag).
//  - Timeout: counter cleared on every pop, increments in ADDR_H..DATA_L while rx_valid=0; on
//    reaching TIMEOUT_CYCLES-1 -> IDLE, err_timeout pulse, no bus access, no reply. Counter
//    width $clog2(TIMEOUT_CYCLES). Not active in IDLE/OP-entry, REQ, ACCESS, RSP.
//  - Back-to-back frames: bytes arriving during REQ/ACCESS/RSP remain in UART; consumed after IDLE.
//  - Reset mid-operation: immediate return to IDLE, strobes/bus_req/tx_wr drop asynchronously,
//    partial frame discarded.
//  - Write to an undefined CSR address: still replies K. Read of undefined address returns bus data.
// STRUCTURE
//  - Shared package/include: opcode and reply byte constants, FSM state encoding (typedef), so
//    the host-side test scripts and bench use the same values.
//  - One natural sub-module: csr_uart_timeout (loadable counter: clr, en, expired pulse).
//  - Bus req/gnt mux with the J1 core lives outside this block (top level).
// TESTING
//  - Write: bytes 57 00 10 00 A5, gnt=1 -> one m_io_wr, m_addr=0010, m_wdata=00A5; tx 4B.
//  - Read: 52 00 11, m_io_din=1234 -> one m_io_rd at addr 0011; tx 12 then 34, no wr strobe.
//  - Grant delay: bus_gnt low 50 cycles -> bus_req held, no strobe until gnt; then one strobe.
//  - Bad opcode 0x41 -> tx 3F, no bus_req; following valid frame completes normally.
//  - Timeout (TIMEOUT_CYCLES=100): 57 00 then silence -> err_timeout pulse at cycle 100, no
//    strobe, no tx; next frame 52 00 11 completes.
//  - tx_ready low 20 cycles during read reply, then async rst mid-ACCESS -> outputs 0 at once.

Source files
------------

// File: rtl/csr_uart_master_pkg.sv
// rtl/csr_uart_master_pkg.sv - shared opcode/reply bytes and FSM encoding for the UART CSR master
// Purpose: one source for the host protocol bytes and state encoding, used by the RTL,
//          the bench and the host-side scripts.
// Ports:   none (package)
package csr_uart_master_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;  // 'W' write frame
  localparam logic [7:0] CMD_RD  = 8'h52;  // 'R' read frame
  localparam logic [7:0] RSP_ACK = 8'h4B;  // 'K' write completed
  localparam logic [7:0] RSP_ERR = 8'h3F;  // '?' unknown opcode

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_OP,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_DATA_H,
    ST_DATA_L,
    ST_REQ,
    ST_ACCESS,
    ST_RSP_0,
    ST_RSP_1
  } state_t;

  typedef enum logic [1:0] {
    OP_WR,
    OP_RD,
    OP_BAD
  } op_t;

  function automatic op_t decode_op(input logic [7:0] b);
    if (b == CMD_WR) return OP_WR;
    if (b == CMD_RD) return OP_RD;
    return OP_BAD;
  endfunction

endpackage

// File: rtl/csr_uart_master_if.sv
// rtl/csr_uart_master_if.sv - UART byte streams and CSR i/o bus bundle for the UART CSR master
// Purpose: groups the rx/tx UART handshakes and the CSR bus (req/gnt, strobes, addr/data).
// Ports:   rx_valid/rx_data/rx_rd    rx UART byte and pop
//          tx_ready/tx_wr/tx_wdata   tx UART push
//          bus_req/bus_gnt           bus ownership handshake with the external mux
//          m_addr/m_wdata/m_io_wr/m_io_rd/m_io_din  single 16-bit i/o access
// Modports: master = the UART CSR master, slave = UARTs + bus side.
interface csr_uart_master_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_rd;
  logic        tx_ready;
  logic        tx_wr;
  logic [7:0]  tx_wdata;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_io_wr;
  logic        m_io_rd;
  logic [15:0] m_io_din;

  modport master (
    input  rx_valid, rx_data, tx_ready, bus_gnt, m_io_din,
    output rx_rd, tx_wr, tx_wdata, bus_req, m_addr, m_wdata, m_io_wr, m_io_rd
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, bus_gnt, m_io_din,
    input  rx_rd, tx_wr, tx_wdata, bus_req, m_addr, m_wdata, m_io_wr, m_io_rd
  );
endinterface

// File: rtl/csr_uart_timeout.sv
// rtl/csr_uart_timeout.sv - inter-byte timeout counter for the UART CSR master
// Purpose: counts idle cycles while enabled; o_expired is high in the cycle the count
//          sits at TIMEOUT_CYCLES-1 with the counter enabled.
// Ports:   clk, rst (async, active-high)
//          i_clr      synchronous clear (wins over i_en)
//          i_en       count this cycle
//          o_expired  combinational expiry pulse
module csr_uart_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_cnt;

  assign o_expired = i_en && (r_cnt == LAST);

  // Holds at LAST on expiry; the owner clears it when it leaves the timed states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_cnt <= '0;
    else if (i_clr)             r_cnt <= '0;
    else if (i_en && !o_expired) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/csr_uart_master.sv
// rtl/csr_uart_master.sv - UART-driven single-access initiator for the CSR i/o bus
// Purpose: parses W AH AL DH DL / R AH AL frames from the rx UART, performs one 16-bit
//          i/o write or read after winning the bus, replies K or RH RL (or ? for a bad opcode).
// Ports:   clk, rst         clock, async active-high reset
//          bus (master)     rx/tx UART handshakes and CSR bus, see csr_uart_master_if
//          busy             high whenever the FSM is not idle
//          err_timeout      one-cycle pulse when a frame is abandoned for inter-byte silence
module csr_uart_master
  import csr_uart_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  csr_uart_master_if.master bus,
  output logic              busy,
  output logic              err_timeout
);
  state_t      r_state;
  state_t      w_next;
  op_t         r_op;
  logic [15:0] r_frame_addr;
  logic [7:0]  r_data_hi;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        r_rx_last;
  logic        r_tx_last;

  logic        w_rx_state;
  logic        w_timed;
  logic        w_rx_rd;
  logic        w_tx_wr;
  logic [7:0]  w_tx_byte;
  logic        w_bus_req;
  logic        w_io_wr;
  logic        w_io_rd;
  logic        w_tmo_exp;
  logic        w_can_tx;

  assign w_rx_state = (r_state == ST_OP) || w_timed;
  assign w_timed    = (r_state == ST_ADDR_H) || (r_state == ST_ADDR_L) ||
                      (r_state == ST_DATA_H) || (r_state == ST_DATA_L);
  // The previous-cycle flags keep a gap after every pop/push: the UARTs drop
  // their valid/ready one cycle late.
  assign w_rx_rd    = w_rx_state && bus.rx_valid && !r_rx_last;
  assign w_can_tx   = bus.tx_ready && !r_tx_last;

  csr_uart_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (!w_timed || w_rx_rd),
    .i_en      (w_timed && !bus.rx_valid),
    .o_expired (w_tmo_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_tx_wr   = 1'b0;
    w_tx_byte = 8'h00;
    w_bus_req = 1'b0;
    w_io_wr   = 1'b0;
    w_io_rd   = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.rx_valid) w_next = ST_OP;
      ST_OP: begin
        if (w_rx_rd) w_next = (decode_op(bus.rx_data) == OP_BAD) ? ST_RSP_0 : ST_ADDR_H;
      end
      ST_ADDR_H, ST_ADDR_L, ST_DATA_H, ST_DATA_L: begin
        if (w_tmo_exp) begin
          w_next = ST_IDLE;
        end else if (w_rx_rd) begin
          case (r_state)
            ST_ADDR_H: w_next = ST_ADDR_L;
            ST_ADDR_L: w_next = (r_op == OP_WR) ? ST_DATA_H : ST_REQ;
            ST_DATA_H: w_next = ST_DATA_L;
            default:   w_next = ST_REQ;
          endcase
        end
      end
      ST_REQ: begin
        w_bus_req = 1'b1;
        if (bus.bus_gnt) w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        w_bus_req = 1'b1;
        // Gated by the grant so a strobe can never reach the bus unowned.
        if (bus.bus_gnt) begin
          w_io_wr = (r_op == OP_WR);
          w_io_rd = (r_op == OP_RD);
          w_next  = ST_RSP_0;
        end
      end
      ST_RSP_0: begin
        case (r_op)
          OP_WR:   w_tx_byte = RSP_ACK;
          OP_RD:   w_tx_byte = r_rdata[15:8];
          default: w_tx_byte = RSP_ERR;
        endcase
        if (w_can_tx) begin
          w_tx_wr = 1'b1;
          w_next  = (r_op == OP_RD) ? ST_RSP_1 : ST_IDLE;
        end
      end
      ST_RSP_1: begin
        w_tx_byte = r_rdata[7:0];
        if (w_can_tx) begin
          w_tx_wr = 1'b1;
          w_next  = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Frame bytes are assembled in shadow registers; m_addr/m_wdata only change
  // on the final pop, so they are stable across REQ and ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op         <= OP_WR;
      r_frame_addr <= '0;
      r_data_hi    <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_rx_last    <= 1'b0;
      r_tx_last    <= 1'b0;
    end else begin
      r_rx_last <= w_rx_rd;
      r_tx_last <= w_tx_wr;
      if (w_rx_rd) begin
        case (r_state)
          ST_OP:     r_op <= decode_op(bus.rx_data);
          ST_ADDR_H: r_frame_addr[15:8] <= bus.rx_data;
          ST_ADDR_L: begin
            r_frame_addr[7:0] <= bus.rx_data;
            if (r_op == OP_RD) r_addr <= {r_frame_addr[15:8], bus.rx_data};
          end
          ST_DATA_H: r_data_hi <= bus.rx_data;
          ST_DATA_L: begin
            r_addr  <= r_frame_addr;
            r_wdata <= {r_data_hi, bus.rx_data};
          end
          default: ;
        endcase
      end
      if (w_io_rd) r_rdata <= bus.m_io_din;
    end
  end

  assign bus.rx_rd    = w_rx_rd;
  assign bus.tx_wr    = w_tx_wr;
  assign bus.tx_wdata = w_tx_byte;
  assign bus.bus_req  = w_bus_req;
  assign bus.m_addr   = r_addr;
  assign bus.m_wdata  = r_wdata;
  assign bus.m_io_wr  = w_io_wr;
  assign bus.m_io_rd  = w_io_rd;
  assign busy         = (r_state != ST_IDLE);
  assign err_timeout  = w_tmo_exp;
endmodule

// File: tb/tb_csr_uart_master.sv
// tb/tb_csr_uart_master.sv - bench for csr_uart_master: UART/bus models plus frame-level reference
module tb_csr_uart_master;
  import csr_uart_master_pkg::*;

  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic err_timeout;

  csr_uart_master_if ifc ();

  csr_uart_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (ifc),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] init_val(input int i);
    logic [31:0] t;
    if (i == 17) return 16'h1234;
    t = i * 40503 + 7;
    return t[15:0];
  endfunction

  // main-owned
  int          gnt_delay = 0;
  int          tx_block  = 0;
  logic [7:0]  rx_buf [0:4095];
  int          wp = 0;
  logic [15:0] ref_mem [0:255];
  logic [32:0] exp_ev [$];
  logic [7:0]  exp_tx [$];
  int          exp_err = 0;
  int          ev_base = 0, tx_base = 0, err_base = 0, req_base = 0;

  // model-owned
  int          rp;
  logic [15:0] slave_mem [0:255];
  logic [32:0] ev_log [0:1023];
  int          ev_cyc [0:1023];
  int          ev_req [0:1023];
  int          ev_lat [0:1023];
  int          n_ev, n_tx, n_req, err_cnt, err_cyc, last_pop, cyc, req_cyc;
  logic [7:0]  tx_log [0:1023];
  int          proto_bad;

  assign ifc.m_io_din = slave_mem[ifc.m_addr[7:0]];

  // UART, arbiter and CSR slave models plus a protocol monitor.
  initial begin
    logic s_rx, s_req, req_fell, prev_rx, prev_tx, prev_req, gnt;
    int gcnt, thold;
    for (int i = 0; i < 256; i++) slave_mem[i] = init_val(i);
    rp = 0; n_ev = 0; n_tx = 0; n_req = 0; err_cnt = 0; err_cyc = 0;
    last_pop = 0; cyc = 0; req_cyc = 0; proto_bad = 0;
    prev_rx = 0; prev_tx = 0; prev_req = 0; gnt = 0; gcnt = 0; thold = 0;
    ifc.rx_valid = 0; ifc.rx_data = 0; ifc.tx_ready = 1; ifc.bus_gnt = 0;
    forever begin
      @(negedge clk);
      cyc++;
      req_fell = 0;
      if (!rst) begin
        if (ifc.rx_rd) begin
          if (prev_rx || !ifc.rx_valid) proto_bad++;
          last_pop = cyc;
        end
        if (ifc.bus_req && !prev_req) begin req_cyc = cyc; n_req++; end
        req_fell = prev_req && !ifc.bus_req;
        if (ifc.m_io_wr || ifc.m_io_rd) begin
          if (!ifc.bus_gnt || !ifc.bus_req || (ifc.m_io_wr && ifc.m_io_rd)) proto_bad++;
          if (n_ev < 1024) begin
            ev_log[n_ev] = {ifc.m_io_wr, ifc.m_addr, ifc.m_io_wr ? ifc.m_wdata : 16'h0};
            ev_cyc[n_ev] = cyc;
            ev_req[n_ev] = req_cyc;
            ev_lat[n_ev] = cyc - last_pop;
          end
          n_ev++;
          if (ifc.m_io_wr) slave_mem[ifc.m_addr[7:0]] = ifc.m_wdata;
        end
        if (ifc.tx_wr) begin
          if (prev_tx || !ifc.tx_ready) proto_bad++;
          if (n_tx < 1024) tx_log[n_tx] = ifc.tx_wdata;
          n_tx++;
        end
        if (err_timeout) begin err_cnt++; err_cyc = cyc; end
      end
      s_rx = ifc.rx_rd; s_req = ifc.bus_req;
      prev_rx = ifc.rx_rd; prev_tx = ifc.tx_wr; prev_req = ifc.bus_req;
      @(posedge clk);
      #1;
      if (rst) begin
        rp = wp; gcnt = 0; thold = 0; gnt = 0;
      end else begin
        if (s_rx && rp < wp) rp++;
        if (!s_req) begin
          gcnt = gnt_delay;
          gnt  = (gnt_delay == 0);
        end else if (gcnt > 0) gcnt--;
        else gnt = 1;
        if (req_fell) thold = tx_block;
        else if (thold > 0) thold--;
      end
      ifc.rx_valid = (rp < wp);
      ifc.rx_data  = (rp < wp) ? rx_buf[rp] : 8'h00;
      ifc.tx_ready = (thold == 0);
      ifc.bus_gnt  = gnt;
    end
  end

  task automatic push(input logic [7:0] b);
    rx_buf[wp] = b;
    wp++;
  endtask

  task automatic model_wr(input logic [15:0] a, input logic [15:0] d);
    push(CMD_WR); push(a[15:8]); push(a[7:0]); push(d[15:8]); push(d[7:0]);
    exp_ev.push_back({1'b1, a, d});
    exp_tx.push_back(RSP_ACK);
    ref_mem[a[7:0]] = d;
  endtask

  task automatic model_rd(input logic [15:0] a);
    logic [15:0] v;
    push(CMD_RD); push(a[15:8]); push(a[7:0]);
    v = ref_mem[a[7:0]];
    exp_ev.push_back({1'b0, a, 16'h0});
    exp_tx.push_back(v[15:8]);
    exp_tx.push_back(v[7:0]);
  endtask

  task automatic model_bad(input logic [7:0] b);
    push(b);
    exp_tx.push_back(RSP_ERR);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    bit park;
    park = (gnt_delay == 0);
    while (n < 5000 && (rp < wp || busy || (n_tx - tx_base) < exp_tx.size())) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk($sformatf("%s/done", tag), n < 5000, 1);
    chk($sformatf("%s/nev", tag), n_ev - ev_base, exp_ev.size());
    chk($sformatf("%s/nreq", tag), n_req - req_base, exp_ev.size());
    for (int i = 0; i < exp_ev.size(); i++) begin
      chk($sformatf("%s/ev%0d", tag, i), (ev_base + i < n_ev) ? ev_log[ev_base + i] : '1, exp_ev[i]);
      if (park && ev_base + i < n_ev)
        chk($sformatf("%s/lat%0d", tag, i), ev_lat[ev_base + i], 2);
    end
    chk($sformatf("%s/ntx", tag), n_tx - tx_base, exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++)
      chk($sformatf("%s/tx%0d", tag, i), (tx_base + i < n_tx) ? tx_log[tx_base + i] : 8'hxx, exp_tx[i]);
    chk($sformatf("%s/err", tag), err_cnt - err_base, exp_err);
    chk($sformatf("%s/proto", tag), proto_bad, 0);
    ev_base = n_ev; tx_base = n_tx; err_base = err_cnt; req_base = n_req;
    exp_ev.delete(); exp_tx.delete(); exp_err = 0;
  endtask

  initial begin
    logic [15:0] a, d;
    logic [7:0]  b;
    int n;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst/busy", busy, 0);
    chk("rst/err", err_timeout, 0);
    chk("rst/rx_rd", ifc.rx_rd, 0);
    chk("rst/tx_wr", ifc.tx_wr, 0);
    chk("rst/tx_wdata", ifc.tx_wdata, 0);
    chk("rst/bus_req", ifc.bus_req, 0);
    chk("rst/m_addr", ifc.m_addr, 0);
    chk("rst/m_wdata", ifc.m_wdata, 0);
    chk("rst/io_wr", ifc.m_io_wr, 0);
    chk("rst/io_rd", ifc.m_io_rd, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    model_wr(16'h0010, 16'h00A5);
    drain("wr");
    model_rd(16'h0011);
    drain("rd");

    gnt_delay = 50;
    model_wr(16'h0020, 16'hBEEF);
    drain("gnt");
    chk("gnt/wait", (ev_cyc[n_ev - 1] - ev_req[n_ev - 1]) >= 50, 1);
    gnt_delay = 0;

    model_bad(8'h41);
    model_rd(16'h0011);
    drain("bad");

    push(CMD_WR); push(8'h00);
    exp_err = 1;
    drain("tmo");
    chk("tmo/cyc", err_cyc - last_pop, TMO);
    model_rd(16'h0011);
    drain("tmo_next");

    tx_block = 20;
    model_rd(16'h0020);
    drain("txblk");
    tx_block = 0;

    for (int it = 0; it < 30; it++) begin
      gnt_delay = $urandom_range(0, 4);
      tx_block  = $urandom_range(0, 5);
      for (int f = $urandom_range(1, 3); f > 0; f--) begin
        a = 16'($urandom);
        d = 16'($urandom);
        case ($urandom_range(0, 4))
          0, 1: model_wr(a, d);
          2, 3: model_rd(a);
          default: begin
            do b = 8'($urandom); while (b == CMD_WR || b == CMD_RD);
            model_bad(b);
          end
        endcase
      end
      drain($sformatf("rnd%0d", it));
    end
    gnt_delay = 0;
    tx_block  = 0;

    model_rd(16'h0033);
    n = 0;
    while (!ifc.m_io_rd && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("arst/reach", n < 1000, 1);
    rst = 1'b1;
    #1;
    chk("arst/bus_req", ifc.bus_req, 0);
    chk("arst/io_rd", ifc.m_io_rd, 0);
    chk("arst/io_wr", ifc.m_io_wr, 0);
    chk("arst/tx_wr", ifc.tx_wr, 0);
    chk("arst/rx_rd", ifc.rx_rd, 0);
    chk("arst/busy", busy, 0);
    chk("arst/m_addr", ifc.m_addr, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    exp_ev.delete(); exp_tx.delete(); exp_err = 0;
    ev_base = n_ev; tx_base = n_tx; err_base = err_cnt; req_base = n_req;

    a = 16'($urandom);
    d = 16'($urandom);
    model_wr(a, d);
    model_rd(a);
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
